key_event_gen: RTL and testbench
================================

# key_event_gen

Key-input front end for the board push-buttons: synchronises a raw button pin, rejects contact bounce, and emits clean single-cycle press, release, long-press and auto-repeat events plus a debounced level. It drives LED and control blocks such as the press-counting LED bar, which need exactly one event per physical press. It is the producer side of the key-event interface those blocks consume.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 270000: consecutive stable synchronised cycles required to accept a level change (10 ms at 27 MHz). Must be ≥ 2.
- LONG_CYCLES, 27000000: cycles in PRESSED before O_long fires (1 s). 0 disables long-press and repeat.
- REPEAT_CYCLES, 5400000: period of O_repeat after O_long (200 ms). 0 disables repeat.
- KEY_ACTIVE_LEVEL, 1: raw I_key level meaning "pressed".

Ports:
- I_clk  input  1  system clock; single clock domain.
- I_rst  input  1  asynchronous, active-high reset.
- I_key  input  1  raw button pin, asynchronous to I_clk.
- O_key_level  output  1  debounced state, 1 = pressed.
- O_press  output  1  one-cycle pulse on an accepted press.
- O_release  output  1  one-cycle pulse on an accepted release.
- O_long  output  1  one-cycle pulse when the hold time reaches LONG_CYCLES.
- O_repeat  output  1  one-cycle pulse every REPEAT_CYCLES after O_long while still held.

## Operation

- Synchroniser: 2 flops. They reset to the released level (~KEY_ACTIVE_LEVEL). Internal `pressed_s` = (sync output == KEY_ACTIVE_LEVEL).
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Reset state is IDLE.
- Debounce counter `db_cnt` has width clog2(DEBOUNCE_CYCLES).
  - IDLE: if pressed_s, go to PRESS_WAIT with db_cnt = 0.
  - PRESS_WAIT: if !pressed_s, return to IDLE (glitch rejected, no output). Otherwise increment db_cnt. When db_cnt == DEBOUNCE_CYCLES-1, go to PRESSED, pulse O_press, set O_key_level = 1, and clear hold_cnt and rpt_cnt.
  - PRESSED: if !pressed_s, go to RELEASE_WAIT with db_cnt = 0. Otherwise increment hold_cnt, which saturates after O_long.
  - RELEASE_WAIT: if pressed_s, return to PRESSED; the hold/repeat counters resume where they froze. Otherwise increment db_cnt. When db_cnt == DEBOUNCE_CYCLES-1, go to IDLE, pulse O_release, set O_key_level = 0, and clear hold_cnt and rpt_cnt. O_key_level stays 1 throughout RELEASE_WAIT.
- Long-press and repeat:
  - Only advance in PRESSED. They are frozen in RELEASE_WAIT and never pulse there.
  - O_long fires once per press, on the cycle hold time reaches LONG_CYCLES.
  - After O_long, rpt_cnt counts. O_repeat fires each time rpt_cnt completes REPEAT_CYCLES, then rpt_cnt restarts.
- Width rules: hold_cnt is clog2(LONG_CYCLES+1) bits and rpt_cnt is clog2(REPEAT_CYCLES+1) bits. No wrap-around is permitted; hold_cnt saturates.
- Output pulse exclusivity:
  - O_press and O_release are never high together.
  - O_long and O_repeat are never high together.
  - O_long and O_repeat are never high in the same cycle as O_press or O_release.

## Timing

- All outputs are registered. Reset value of every output is 0, applied asynchronously on I_rst.
- Press latency: if I_key is held pressed from sampling edge E0, PRESSED is entered at edge E0+DEBOUNCE_CYCLES+2. O_press is high and O_key_level rises in the cycle after that edge.
- Release latency: symmetric. A stable release from edge R0 gives O_release and O_key_level = 0 after edge R0+DEBOUNCE_CYCLES+2.
- Let Ep = the edge entering PRESSED, with no intervening bounce.
  - O_long is high after edge Ep+LONG_CYCLES.
  - O_repeat is high after edges Ep+LONG_CYCLES+k·REPEAT_CYCLES, for k ≥ 1.
- Any bounce shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change.
- Reset mid-operation: all state, counters and outputs clear immediately.
  - If the key is still held at deassertion, it is treated as a new press: O_press fires DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
  - No O_release is generated for the press interrupted by reset.

## Test plan

Parameters for all scenarios: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, KEY_ACTIVE_LEVEL=1.

1. Clean press from E0, held 60 cycles → O_press after E6; O_key_level=1; O_long after E26; O_repeat after E34, E42, E50, E58; no other pulses.
2. Press bounce (3 pressed / 1 released, repeated 5×), then stable → exactly one O_press, DEBOUNCE_CYCLES+2 edges after the stable run starts.
3. Release with bounce (2-cycle released glitches) while held → O_key_level stays 1, no O_release; hold timing delayed by the glitch cycles; a final stable release gives O_release 6 edges later.
4. Press held 15 cycles in PRESSED, then released → O_press and O_release only; no O_long; counters clear (next press needs a full 20 cycles).
5. I_rst asserted mid-repeat with key held → all outputs 0 asynchronously; after deassert, O_press 6 edges later; no O_release emitted.
6. KEY_ACTIVE_LEVEL=0, I_key idle high, driven low → same event sequence as scenario 1; reset with I_key high gives no spurious press.

Source files
------------

// File: rtl/key_event_gen.sv
// Push-button front end: two-flop synchroniser, debounce FSM and hold timers that
// turn a bouncy raw pin into single-cycle press/release/long/repeat pulses.
module key_event_gen #(
    parameter int   DEBOUNCE_CYCLES  = 270000,
    parameter int   LONG_CYCLES      = 27000000,
    parameter int   REPEAT_CYCLES    = 5400000,
    parameter logic KEY_ACTIVE_LEVEL = 1'b1
) (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_key,
    output logic O_key_level,
    output logic O_press,
    output logic O_release,
    output logic O_long,
    output logic O_repeat
);

    localparam int  DB_W      = $clog2(DEBOUNCE_CYCLES);
    localparam bit  LONG_EN   = (LONG_CYCLES > 0);
    localparam bit  REPEAT_EN = LONG_EN && (REPEAT_CYCLES > 0);
    localparam int  HOLD_W    = LONG_EN ? $clog2(LONG_CYCLES + 1) : 1;
    localparam int  RPT_W     = REPEAT_EN ? $clog2(REPEAT_CYCLES + 1) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_EN ? LONG_CYCLES - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_EN ? LONG_CYCLES : 0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_EN ? REPEAT_CYCLES - 1 : 0);
    localparam logic [RPT_W-1:0]  RPT_ONE   = RPT_W'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [1:0]        sync_r;
    logic              pressed_s;
    state_t            state_r;
    logic [DB_W-1:0]   db_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [RPT_W-1:0]  rpt_cnt_r;

    // Two-flop synchroniser for the asynchronous pin; resets to the released level.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            sync_r <= {2{~KEY_ACTIVE_LEVEL}};
        end else begin
            sync_r <= {sync_r[0], I_key};
        end
    end

    assign pressed_s = (sync_r[1] == KEY_ACTIVE_LEVEL);

    // Debounce FSM with hold/repeat timers; every output is a register.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_r     <= IDLE;
            db_cnt_r    <= '0;
            hold_cnt_r  <= '0;
            rpt_cnt_r   <= '0;
            O_key_level <= 1'b0;
            O_press     <= 1'b0;
            O_release   <= 1'b0;
            O_long      <= 1'b0;
            O_repeat    <= 1'b0;
        end else begin
            O_press   <= 1'b0;
            O_release <= 1'b0;
            O_long    <= 1'b0;
            O_repeat  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pressed_s) begin
                        state_r  <= PRESS_WAIT;
                        db_cnt_r <= '0;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_s) begin
                        state_r <= IDLE;
                    end else if (db_cnt_r == DB_LAST) begin
                        state_r     <= PRESSED;
                        O_press     <= 1'b1;
                        O_key_level <= 1'b1;
                        hold_cnt_r  <= '0;
                        rpt_cnt_r   <= '0;
                    end else begin
                        db_cnt_r <= db_cnt_r + DB_ONE;
                    end
                end
                PRESSED: begin
                    if (!pressed_s) begin
                        state_r  <= RELEASE_WAIT;
                        db_cnt_r <= '0;
                    end else if (LONG_EN && (hold_cnt_r != HOLD_MAX)) begin
                        // hold_cnt parks at HOLD_MAX once O_long has fired
                        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                        O_long     <= (hold_cnt_r == HOLD_LAST);
                    end else if (REPEAT_EN) begin
                        if (rpt_cnt_r == RPT_LAST) begin
                            rpt_cnt_r <= '0;
                            O_repeat  <= 1'b1;
                        end else begin
                            rpt_cnt_r <= rpt_cnt_r + RPT_ONE;
                        end
                    end else begin
                        state_r <= PRESSED;
                    end
                end
                RELEASE_WAIT: begin
                    // timers stay frozen here; a return to PRESSED resumes them
                    if (pressed_s) begin
                        state_r <= PRESSED;
                    end else if (db_cnt_r == DB_LAST) begin
                        state_r     <= IDLE;
                        O_release   <= 1'b1;
                        O_key_level <= 1'b0;
                        hold_cnt_r  <= '0;
                        rpt_cnt_r   <= '0;
                    end else begin
                        db_cnt_r <= db_cnt_r + DB_ONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    O_key_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_gen.sv
// Scoreboard bench for key_event_gen: expected pulses are queued with their cycle
// as stimulus is scheduled, and a monitor pops and compares them as pulses appear.
module tb_key_event_gen;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;
    localparam int K_REPEAT  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, key_a, key_b;
    logic lvl_a, prs_a, rel_a, lng_a, rpt_a;
    logic lvl_b, prs_b, rel_b, lng_b, rpt_b;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    ev_t exp_a[$];
    ev_t exp_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    key_event_gen #(
        .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .KEY_ACTIVE_LEVEL(1'b1)
    ) dut_a (
        .I_clk(clk), .I_rst(rst_a), .I_key(key_a),
        .O_key_level(lvl_a), .O_press(prs_a), .O_release(rel_a),
        .O_long(lng_a), .O_repeat(rpt_a)
    );

    key_event_gen #(
        .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .KEY_ACTIVE_LEVEL(1'b0)
    ) dut_b (
        .I_clk(clk), .I_rst(rst_b), .I_key(key_b),
        .O_key_level(lvl_b), .O_press(prs_b), .O_release(rel_b),
        .O_long(lng_b), .O_repeat(rpt_b)
    );

    function automatic string kname(input int k);
        case (k)
            K_PRESS:   return "press";
            K_RELEASE: return "release";
            K_LONG:    return "long";
            K_REPEAT:  return "repeat";
            default:   return "none";
        endcase
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // key value v is sampled by the DUT at edge e
    task automatic drive_a(input logic v, input int e);
        wait_until(e - 1);
        key_a = v;
    endtask

    task automatic drive_b(input logic v, input int e);
        wait_until(e - 1);
        key_b = v;
    endtask

    task automatic push_a(input int c, input int k);
        exp_a.push_back('{cyc: c, kind: k});
    endtask

    task automatic push_b(input int c, input int k);
        exp_b.push_back('{cyc: c, kind: k});
    endtask

    // Pops one expected event per observed pulse and compares cycle and kind.
    task automatic monitor();
        logic [3:0] pa, pb;
        ev_t e;
        forever begin
            @(negedge clk);
            pa = {rpt_a, lng_a, rel_a, prs_a};
            pb = {rpt_b, lng_b, rel_b, prs_b};
            for (int k = 0; k < 4; k++) begin
                if (pa[k]) begin
                    vectors++;
                    if (exp_a.size() == 0) begin
                        miscompares++;
                        $display("FAIL evt_a: got %s at cycle %0d, required no event", kname(k), cyc);
                    end else begin
                        e = exp_a.pop_front();
                        if (e.cyc !== cyc || e.kind !== k) begin
                            miscompares++;
                            $display("FAIL evt_a: got %s at cycle %0d, required %s at cycle %0d",
                                     kname(k), cyc, kname(e.kind), e.cyc);
                        end
                    end
                end
                if (pb[k]) begin
                    vectors++;
                    if (exp_b.size() == 0) begin
                        miscompares++;
                        $display("FAIL evt_b: got %s at cycle %0d, required no event", kname(k), cyc);
                    end else begin
                        e = exp_b.pop_front();
                        if (e.cyc !== cyc || e.kind !== k) begin
                            miscompares++;
                            $display("FAIL evt_b: got %s at cycle %0d, required %s at cycle %0d",
                                     kname(k), cyc, kname(e.kind), e.cyc);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({lvl_a, prs_a, rel_a, lng_a, rpt_a, lvl_b, prs_b, rel_b, lng_b, rpt_b} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got a=%b%b%b%b%b b=%b%b%b%b%b, required all 0",
                     lvl_a, prs_a, rel_a, lng_a, rpt_a, lvl_b, prs_b, rel_b, lng_b, rpt_b);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        wait_until(cyc + 12);
        vectors++;
        if (lvl_a !== 1'b0 || lvl_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_level: got a=%b b=%b, required 0 0", lvl_a, lvl_b);
        end
    endtask

    task automatic test_clean_press();
        int e0;
        e0 = cyc + 2;
        push_a(e0 + 6, K_PRESS);
        push_a(e0 + 26, K_LONG);
        for (int k = 1; k <= 4; k++) push_a(e0 + 26 + k * REP, K_REPEAT);
        push_a(e0 + 66, K_RELEASE);
        drive_a(1'b1, e0);
        wait_until(e0 + 5);
        vectors++;
        if (lvl_a !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_level_before: got %b, required 0", lvl_a);
        end
        wait_until(e0 + 6);
        vectors++;
        if (lvl_a !== 1'b1) begin
            miscompares++;
            $display("FAIL clean_level_rise: got %b, required 1", lvl_a);
        end
        drive_a(1'b0, e0 + 60);
        wait_until(e0 + 65);
        vectors++;
        if (lvl_a !== 1'b1) begin
            miscompares++;
            $display("FAIL clean_level_hold: got %b, required 1", lvl_a);
        end
        wait_until(e0 + 66);
        vectors++;
        if (lvl_a !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_level_fall: got %b, required 0", lvl_a);
        end
        wait_until(e0 + 70);
        vectors++;
        if (exp_a.size() != 0) begin
            miscompares++;
            $display("FAIL clean_drain: got %0d events outstanding, required 0", exp_a.size());
        end
    endtask

    task automatic test_press_bounce();
        int b, s;
        b = cyc + 2;
        s = b + 20;
        push_a(s + 6, K_PRESS);
        push_a(s + 16, K_RELEASE);
        for (int i = 0; i < 5; i++) begin
            drive_a(1'b1, b + 4 * i);
            drive_a(1'b0, b + 4 * i + 3);
        end
        drive_a(1'b1, s);
        wait_until(s + 5);
        vectors++;
        if (lvl_a !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce_level_low: got %b, required 0", lvl_a);
        end
        drive_a(1'b0, s + 10);
        wait_until(s + 20);
        vectors++;
        if (exp_a.size() != 0) begin
            miscompares++;
            $display("FAIL bounce_drain: got %0d events outstanding, required 0", exp_a.size());
        end
    endtask

    // Each 2-cycle release glitch costs 3 hold edges: leaving PRESSED, one
    // RELEASE_WAIT count, and the edge that returns to PRESSED.
    task automatic test_release_bounce();
        int e0;
        e0 = cyc + 2;
        push_a(e0 + 6, K_PRESS);
        push_a(e0 + 32, K_LONG);
        push_a(e0 + 40, K_RELEASE);
        drive_a(1'b1, e0);
        drive_a(1'b0, e0 + 10);
        drive_a(1'b1, e0 + 12);
        wait_until(e0 + 13);
        vectors++;
        if (lvl_a !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_level: got %b, required 1", lvl_a);
        end
        drive_a(1'b0, e0 + 16);
        drive_a(1'b1, e0 + 18);
        drive_a(1'b0, e0 + 34);
        wait_until(e0 + 39);
        vectors++;
        if (lvl_a !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_level_rw: got %b, required 1", lvl_a);
        end
        wait_until(e0 + 44);
        vectors++;
        if (exp_a.size() != 0 || lvl_a !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_drain: got %0d outstanding level %b, required 0 level 0",
                     exp_a.size(), lvl_a);
        end
    endtask

    task automatic test_short_hold();
        int e0, e1;
        e0 = cyc + 2;
        e1 = e0 + 30;
        push_a(e0 + 6, K_PRESS);
        push_a(e0 + 26, K_RELEASE);
        push_a(e1 + 6, K_PRESS);
        push_a(e1 + 26, K_LONG);
        push_a(e1 + 34, K_RELEASE);
        drive_a(1'b1, e0);
        drive_a(1'b0, e0 + 20);
        drive_a(1'b1, e1);
        drive_a(1'b0, e1 + 28);
        wait_until(e1 + 38);
        vectors++;
        if (exp_a.size() != 0) begin
            miscompares++;
            $display("FAIL short_drain: got %0d events outstanding, required 0", exp_a.size());
        end
    endtask

    task automatic test_reset_mid_repeat();
        int e0, f;
        e0 = cyc + 2;
        push_a(e0 + 6, K_PRESS);
        push_a(e0 + 26, K_LONG);
        push_a(e0 + 34, K_REPEAT);
        push_a(e0 + 42, K_REPEAT);
        drive_a(1'b1, e0);
        wait_until(e0 + 44);
        #2 rst_a = 1'b1;
        #1;
        vectors++;
        if ({lvl_a, prs_a, rel_a, lng_a, rpt_a} !== 5'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %b%b%b%b%b, required 00000",
                     lvl_a, prs_a, rel_a, lng_a, rpt_a);
        end
        repeat (2) @(negedge clk);
        f = cyc + 1;
        push_a(f + 6, K_PRESS);
        push_a(f + 16, K_RELEASE);
        rst_a = 1'b0;
        wait_until(f + 5);
        vectors++;
        if (lvl_a !== 1'b0) begin
            miscompares++;
            $display("FAIL rerst_level_low: got %b, required 0", lvl_a);
        end
        wait_until(f + 6);
        vectors++;
        if (lvl_a !== 1'b1) begin
            miscompares++;
            $display("FAIL rerst_level_high: got %b, required 1", lvl_a);
        end
        drive_a(1'b0, f + 10);
        wait_until(f + 20);
        vectors++;
        if (exp_a.size() != 0) begin
            miscompares++;
            $display("FAIL rerst_drain: got %0d events outstanding, required 0", exp_a.size());
        end
    endtask

    task automatic test_active_low();
        int e0;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        wait_until(cyc + 10);
        vectors++;
        if (lvl_b !== 1'b0) begin
            miscompares++;
            $display("FAIL low_idle_level: got %b, required 0", lvl_b);
        end
        e0 = cyc + 2;
        push_b(e0 + 6, K_PRESS);
        push_b(e0 + 26, K_LONG);
        for (int k = 1; k <= 4; k++) push_b(e0 + 26 + k * REP, K_REPEAT);
        push_b(e0 + 66, K_RELEASE);
        drive_b(1'b0, e0);
        wait_until(e0 + 6);
        vectors++;
        if (lvl_b !== 1'b1) begin
            miscompares++;
            $display("FAIL low_level_rise: got %b, required 1", lvl_b);
        end
        drive_b(1'b1, e0 + 60);
        wait_until(e0 + 70);
        vectors++;
        if (exp_b.size() != 0 || lvl_b !== 1'b0) begin
            miscompares++;
            $display("FAIL low_drain: got %0d outstanding level %b, required 0 level 0",
                     exp_b.size(), lvl_b);
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        key_a = 1'b0;
        key_b = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_short_hold();
        test_reset_mid_repeat();
        test_active_low();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

endmodule
